// File: rtl/heapsort_siftdown_ctrl.sv
// Sift-down engine: restores the max-heap property below a root by walking down the
// heap and handing index pairs to the external combinational swap stage.
//
// state | meaning
// IDLE  | waiting for start_i; latches vector, size, root
// CMP   | compare cur with its children, pick the largest
// SWAP  | capture swap stage result, descend to the swapped child
// DONE  | one-cycle completion pulse
module heapsort_siftdown_ctrl #(
   parameter int N  = 5,
   parameter int W  = 32,
   parameter int IW = 16
) (
   input  logic            system1000,
   input  logic            system1000_rstn,
   input  logic            start_i,
   input  logic [N*W-1:0]  vec_i,
   input  logic [IW-1:0]   root_i,
   input  logic [IW-1:0]   size_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [N*W-1:0]  vec_o,
   output logic [N*W-1:0]  swap_vec_o,
   output logic [IW-1:0]   swap_i_o,
   output logic [IW-1:0]   swap_j_o,
   input  logic [N*W-1:0]  swap_res_i
);

   typedef enum logic [1:0] {S_IDLE, S_CMP, S_SWAP, S_DONE} state_t;

   localparam logic [IW-1:0] N_IW = IW'(N);

   state_t          state_q, state_d;
   logic [N*W-1:0]  vec_q, vec_d;
   logic [IW-1:0]   sz_q, sz_d;
   logic [IW-1:0]   cur_q, cur_d;
   logic [IW-1:0]   swap_i_q, swap_i_d;
   logic [IW-1:0]   swap_j_q, swap_j_d;

   logic [IW-1:0]         sz_clamp;
   logic [IW:0]           cur_x, l_x, r_x, sz_x, lg_x;
   logic signed [W-1:0]   lg_val, l_val, r_val;

   // Out-of-range indices read as 0; callers only use them after a bounds check.
   function automatic logic signed [W-1:0] elem(input logic [N*W-1:0] v, input logic [IW:0] idx);
      logic signed [W-1:0] e;
      e = '0;
      for (int k = 0; k < N; k++) begin
         if (idx == (IW+1)'(k)) e = v[(N-1-k)*W +: W];
      end
      return e;
   endfunction

   always_comb begin
      sz_clamp = (size_i > N_IW) ? N_IW : size_i;
      cur_x    = {1'b0, cur_q};
      l_x      = {cur_q, 1'b1};
      r_x      = l_x + (IW+1)'(1);
      sz_x     = {1'b0, sz_q};
      l_val    = elem(vec_q, l_x);
      r_val    = elem(vec_q, r_x);
      lg_x     = cur_x;
      lg_val   = elem(vec_q, cur_x);
      // Strict greater-than keeps the earlier candidate on ties.
      if (l_x < sz_x && l_val > lg_val) begin
         lg_x   = l_x;
         lg_val = l_val;
      end
      if (r_x < sz_x && r_val > lg_val) begin
         lg_x   = r_x;
         lg_val = r_val;
      end
   end

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      sz_d     = sz_q;
      cur_d    = cur_q;
      swap_i_d = swap_i_q;
      swap_j_d = swap_j_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               vec_d   = vec_i;
               sz_d    = sz_clamp;
               cur_d   = root_i;
               state_d = (root_i >= sz_clamp) ? S_DONE : S_CMP;
            end
         end
         S_CMP: begin
            if (lg_x == cur_x) begin
               state_d = S_DONE;
            end else begin
               swap_i_d = cur_q;
               swap_j_d = lg_x[IW-1:0];
               state_d  = S_SWAP;
            end
         end
         S_SWAP: begin
            vec_d   = swap_res_i;
            cur_d   = swap_j_q;
            state_d = S_CMP;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge system1000) begin
      if (!system1000_rstn) begin
         state_q  <= S_IDLE;
         vec_q    <= '0;
         sz_q     <= '0;
         cur_q    <= '0;
         swap_i_q <= '0;
         swap_j_q <= '0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         sz_q     <= sz_d;
         cur_q    <= cur_d;
         swap_i_q <= swap_i_d;
         swap_j_q <= swap_j_d;
      end
   end

   assign busy_o     = (state_q == S_CMP) || (state_q == S_SWAP);
   assign done_o     = (state_q == S_DONE);
   assign vec_o      = vec_q;
   assign swap_vec_o = vec_q;
   assign swap_i_o   = swap_i_q;
   assign swap_j_o   = swap_j_q;

endmodule

// File: tb/tb_heapsort_siftdown_ctrl.sv
// Directed bench for heapsort_siftdown_ctrl with a behavioural swap stage in the loop.
module tb_heapsort_siftdown_ctrl;
   localparam int N  = 5;
   localparam int W  = 32;
   localparam int IW = 16;
   localparam int VW = N*W;

   logic          clk;
   logic          rstn;
   logic          start_i;
   logic [VW-1:0] vec_i;
   logic [IW-1:0] root_i;
   logic [IW-1:0] size_i;
   logic          busy_o;
   logic          done_o;
   logic [VW-1:0] vec_o;
   logic [VW-1:0] swap_vec_o;
   logic [IW-1:0] swap_i_o;
   logic [IW-1:0] swap_j_o;
   logic [VW-1:0] swap_res;

   heapsort_siftdown_ctrl #(.N(N), .W(W), .IW(IW)) dut (
      .system1000      (clk),
      .system1000_rstn (rstn),
      .start_i         (start_i),
      .vec_i           (vec_i),
      .root_i          (root_i),
      .size_i          (size_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .vec_o           (vec_o),
      .swap_vec_o      (swap_vec_o),
      .swap_i_o        (swap_i_o),
      .swap_j_o        (swap_j_o),
      .swap_res_i      (swap_res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Swap stage model: exchange elements swap_i_o and swap_j_o.
   always_comb begin
      int a, b;
      swap_res = swap_vec_o;
      a = int'(swap_i_o);
      b = int'(swap_j_o);
      if (a < N && b < N) begin
         swap_res[(N-1-a)*W +: W] = swap_vec_o[(N-1-b)*W +: W];
         swap_res[(N-1-b)*W +: W] = swap_vec_o[(N-1-a)*W +: W];
      end
   end

   typedef struct {
      string         name;
      logic [VW-1:0] vin;
      int            root;
      int            size;
      logic [VW-1:0] vexp;
      int            done_cyc;
      int            nsw;
      int            si0, sj0, si1, sj1;
   } vec_t;

   int pass_cnt = 0;
   int total_cnt = 0;

   function automatic logic [VW-1:0] pk(input int e0, input int e1, input int e2,
                                        input int e3, input int e4);
      return {e0, e1, e2, e3, e4};
   endfunction

   task automatic check(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t t, input bit pulse_mid);
      int n, done_at, nsw;
      int si[4];
      int sj[4];
      done_at = 0;
      nsw = 0;
      vec_i   = t.vin;
      root_i  = IW'(t.root);
      size_i  = IW'(t.size);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      vec_i   = pk(99, 98, 97, 96, 95);
      root_i  = '0;
      size_i  = IW'(5);
      n = 1;
      check({t.name, " busy@T+1"}, VW'(busy_o), VW'(t.done_cyc > 1));
      while (n <= 12 && done_at == 0) begin
         if (done_o) begin
            done_at = n;
         end else begin
            if (busy_o && (n % 2 == 0) && nsw < 4) begin
               si[nsw] = int'(swap_i_o);
               sj[nsw] = int'(swap_j_o);
               nsw++;
            end
            if (pulse_mid && n == 2) begin
               start_i = 1'b1;
               vec_i   = pk(-50, 40, 30, 20, 10);
               root_i  = IW'(1);
               size_i  = IW'(2);
            end else begin
               start_i = 1'b0;
            end
            step();
            n++;
         end
      end
      start_i = 1'b0;
      check({t.name, " done cycle"}, VW'(done_at), VW'(t.done_cyc));
      check({t.name, " swap count"}, VW'(nsw), VW'(t.nsw));
      if (nsw >= 1 && t.nsw >= 1) begin
         check({t.name, " swap0 i"}, VW'(si[0]), VW'(t.si0));
         check({t.name, " swap0 j"}, VW'(sj[0]), VW'(t.sj0));
      end
      if (nsw >= 2 && t.nsw >= 2) begin
         check({t.name, " swap1 i"}, VW'(si[1]), VW'(t.si1));
         check({t.name, " swap1 j"}, VW'(sj[1]), VW'(t.sj1));
      end
      check({t.name, " vec_o"}, vec_o, t.vexp);
      check({t.name, " busy at done"}, VW'(busy_o), VW'(0));
      step();
      check({t.name, " done one cycle"}, VW'(done_o), VW'(0));
      check({t.name, " vec_o held"}, vec_o, t.vexp);
   endtask

   vec_t tbl[8];

   initial begin
      vec_t s1;
      tbl[0] = '{"two_level", pk(1,5,3,4,2), 0, 5, pk(5,4,3,1,2), 6, 2, 0, 1, 1, 3};
      tbl[1] = '{"heap_ok", pk(9,7,8,1,2), 0, 5, pk(9,7,8,1,2), 2, 0, 0, 0, 0, 0};
      tbl[2] = '{"signed_tie", pk(-3,-1,-1,-8,-9), 0, 5, pk(-1,-3,-1,-8,-9), 4, 1, 0, 1, 0, 0};
      tbl[3] = '{"clamp", pk(0,0,0,0,7), 1, 9, pk(0,7,0,0,0), 4, 1, 1, 4, 0, 0};
      tbl[4] = '{"root_oob", pk(1,2,3,4,5), 3, 3, pk(1,2,3,4,5), 1, 0, 0, 0, 0, 0};
      tbl[5] = '{"size_zero", pk(1,2,3,4,5), 0, 0, pk(1,2,3,4,5), 1, 0, 0, 0, 0, 0};
      tbl[6] = '{"size_two", pk(1,2,9,0,0), 0, 2, pk(2,1,9,0,0), 4, 1, 0, 1, 0, 0};
      tbl[7] = '{"neg_kids", pk(0,-5,-7,0,0), 0, 5, pk(0,-5,-7,0,0), 2, 0, 0, 0, 0, 0};
      s1 = tbl[0];

      rstn = 1'b0; start_i = 1'b0; vec_i = '0; root_i = '0; size_i = '0;
      step(); step();
      check("reset vec_o", vec_o, '0);
      check("reset busy/done", VW'({busy_o, done_o}), VW'(0));
      check("reset swap idx", VW'({swap_i_o, swap_j_o}), VW'(0));
      rstn = 1'b1;
      step();

      for (int i = 0; i < 8; i++) run_vec(tbl[i], 1'b0);

      check("swap_i held", VW'(swap_i_o), VW'(0));
      check("swap_j held", VW'(swap_j_o), VW'(1));

      // Reset in the middle of the first scenario.
      vec_i = s1.vin; root_i = '0; size_i = IW'(5); start_i = 1'b1;
      step();
      start_i = 1'b0;
      step(); step();
      rstn = 1'b0;
      step();
      check("midrst busy", VW'(busy_o), VW'(0));
      check("midrst done", VW'(done_o), VW'(0));
      check("midrst vec_o", vec_o, '0);
      check("midrst swap idx", VW'({swap_i_o, swap_j_o}), VW'(0));
      rstn = 1'b1;
      step();
      check("midrst no late done", VW'({busy_o, done_o}), VW'(0));
      run_vec(s1, 1'b0);

      // Reset asserted together with start.
      rstn = 1'b0; vec_i = s1.vin; start_i = 1'b1;
      step();
      start_i = 1'b0; rstn = 1'b1;
      step();
      check("rst beats start", VW'({busy_o, done_o}), VW'(0));

      s1.name = "start_during_busy";
      run_vec(s1, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
